// File: rtl/store_commit_ctrl_pkg.sv
// Shared widths and entry/FSM encodings for the store commit controller.
// Optional flush port is enabled by defining STORE_FLUSH_EN.
package store_commit_ctrl_pkg;
  localparam int STORER_NUM = 2;
  localparam int WORD_SIZE  = 32;
  localparam int RB_INDEX   = 4;
  localparam int QDEPTH     = 4;

  localparam logic [1:0] ST_FREE      = 2'd0;
  localparam logic [1:0] ST_DONE      = 2'd1;
  localparam logic [1:0] ST_COMMITTED = 2'd2;

  localparam logic [0:0] MS_IDLE  = 1'b0;
  localparam logic [0:0] MS_WRITE = 1'b1;
endpackage

// File: rtl/store_commit_ctrl_rr_arbiter.sv
// N-way round-robin arbiter: the first requester at or after i_ptr wins;
// its index is reported so the owner can advance the pointer.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);
  int w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = PW'(w_j);
      end
    end
  end
endmodule

// File: rtl/store_commit_ctrl.sv
// Store queue between store RSs and memory: captures stores, waits for
// ROB commit, writes in commit order. Flush port under STORE_FLUSH_EN.
module store_commit_ctrl #(
  parameter int STORER_NUM = store_commit_ctrl_pkg::STORER_NUM,
  parameter int WORD_SIZE  = store_commit_ctrl_pkg::WORD_SIZE,
  parameter int RB_INDEX   = store_commit_ctrl_pkg::RB_INDEX,
  parameter int QDEPTH     = store_commit_ctrl_pkg::QDEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [STORER_NUM-1:0]          st_valid,
  input  logic [STORER_NUM*WORD_SIZE-1:0] st_addr,
  input  logic [STORER_NUM*WORD_SIZE-1:0] st_data,
  input  logic [STORER_NUM*RB_INDEX-1:0] st_rb,
  output logic [STORER_NUM-1:0]          st_grant,
  input  logic                           commit_valid,
  input  logic [RB_INDEX-1:0]            commit_rb,
  output logic                           commit_ack,
  output logic                           mem_we,
  output logic [WORD_SIZE-1:0]           mem_addr,
  output logic [WORD_SIZE-1:0]           mem_wdata,
  input  logic                           mem_ready,
`ifdef STORE_FLUSH_EN
  input  logic                           flush,
`endif
  output logic                           q_full,
  output logic [$clog2(QDEPTH):0]        q_count
);
  import store_commit_ctrl_pkg::*;

  localparam int PW = (STORER_NUM > 1) ? $clog2(STORER_NUM) : 1;
  localparam int SW = $clog2(QDEPTH);
  localparam int CW = SW + 1;

  logic [1:0]           r_st   [QDEPTH];
  logic [WORD_SIZE-1:0] r_addr [QDEPTH];
  logic [WORD_SIZE-1:0] r_data [QDEPTH];
  logic [RB_INDEX-1:0]  r_rb   [QDEPTH];
  logic [SW-1:0]        r_fifo [QDEPTH];
  logic [SW-1:0]        r_head;
  logic [SW-1:0]        r_tail;
  logic [CW-1:0]        r_fcnt;
  logic [PW-1:0]        r_ptr;
  logic [0:0]           r_ms;
  logic                 r_ack;
  logic [WORD_SIZE-1:0] r_maddr;
  logic [WORD_SIZE-1:0] r_mwdata;
  logic                 r_full;
  logic [CW-1:0]        r_count;

  logic                 w_flush;
  logic                 w_has_free;
  logic [SW-1:0]        w_free_idx;
  logic [STORER_NUM-1:0] w_arb_grant;
  logic [PW-1:0]        w_arb_idx;
  logic                 w_arb_any;
  logic                 w_grant_en;
  logic                 w_hit;
  logic [SW-1:0]        w_hit_idx;
  logic                 w_commit;
  logic                 w_pop;
  logic                 w_start;
  logic [SW-1:0]        w_head_slot;
  logic [1:0]           w_st_n [QDEPTH];
  logic [CW-1:0]        w_cnt_n;

`ifdef STORE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = QDEPTH - 1; i >= 0; i--) begin
      if (r_st[i] == ST_FREE) begin
        w_has_free = 1'b1;
        w_free_idx = SW'(i);
      end
    end
  end

  rr_arbiter #(.N(STORER_NUM), .PW(PW)) u_arb (
    .i_req  (st_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_arb_grant),
    .o_idx  (w_arb_idx),
    .o_any  (w_arb_any)
  );

  // grant sees only slots free at the start of the cycle
  assign w_grant_en = w_arb_any && w_has_free && !w_flush && !reset;
  assign st_grant   = w_grant_en ? w_arb_grant : '0;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (r_st[i] == ST_DONE && r_rb[i] == commit_rb) begin
        w_hit     = 1'b1;
        w_hit_idx = SW'(i);
      end
    end
  end

  assign w_commit    = commit_valid && w_hit && !w_flush;
  assign w_head_slot = r_fifo[r_head];
  assign w_pop       = (r_ms == MS_WRITE) && mem_ready;
  assign w_start     = (r_ms == MS_IDLE) && (r_fcnt != '0);

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      w_st_n[i] = r_st[i];
      if (w_flush && r_st[i] == ST_DONE)
        w_st_n[i] = ST_FREE;
    end
    if (w_pop)
      w_st_n[w_head_slot] = ST_FREE;
    if (w_commit)
      w_st_n[w_hit_idx] = ST_COMMITTED;
    if (w_grant_en)
      w_st_n[w_free_idx] = ST_DONE;
    w_cnt_n = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (w_st_n[i] != ST_FREE)
        w_cnt_n = w_cnt_n + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++)
        r_st[i] <= ST_FREE;
      r_head   <= '0;
      r_tail   <= '0;
      r_fcnt   <= '0;
      r_ptr    <= '0;
      r_ms     <= MS_IDLE;
      r_ack    <= 1'b0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_full   <= 1'b0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++)
        r_st[i] <= w_st_n[i];
      r_ack   <= w_commit;
      r_count <= w_cnt_n;
      r_full  <= (w_cnt_n == CW'(QDEPTH));
      if (w_grant_en)
        r_ptr <= (w_arb_idx == PW'(STORER_NUM - 1)) ? '0
                 : w_arb_idx + PW'(1);
      if (w_commit)
        r_tail <= r_tail + SW'(1);
      if (w_pop)
        r_head <= r_head + SW'(1);
      r_fcnt <= r_fcnt + CW'(w_commit) - CW'(w_pop);
      if (w_start) begin
        r_ms     <= MS_WRITE;
        r_maddr  <= r_addr[w_head_slot];
        r_mwdata <= r_data[w_head_slot];
      end else if (w_pop) begin
        r_ms <= MS_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant_en) begin
      r_addr[w_free_idx] <= st_addr[w_arb_idx*WORD_SIZE +: WORD_SIZE];
      r_data[w_free_idx] <= st_data[w_arb_idx*WORD_SIZE +: WORD_SIZE];
      r_rb[w_free_idx]   <= st_rb[w_arb_idx*RB_INDEX +: RB_INDEX];
    end
    if (w_commit)
      r_fifo[r_tail] <= w_hit_idx;
  end

  assign commit_ack = r_ack;
  assign mem_we     = (r_ms == MS_WRITE);
  assign mem_addr   = r_maddr;
  assign mem_wdata  = r_mwdata;
  assign q_full     = r_full;
  assign q_count    = r_count;
endmodule

// File: tb/tb_store_commit_ctrl.sv
// Bench for store_commit_ctrl: directed vector table, hand sequences and
// random traffic against a queue-based reference model.
module tb_store_commit_ctrl;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int R  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   st_valid = '0;
  logic [N*W-1:0] st_addr = '0;
  logic [N*W-1:0] st_data = '0;
  logic [N*R-1:0] st_rb = '0;
  logic [N-1:0]   st_grant;
  logic           commit_valid = 1'b0;
  logic [R-1:0]   commit_rb = '0;
  logic           commit_ack;
  logic           mem_we;
  logic [W-1:0]   mem_addr;
  logic [W-1:0]   mem_wdata;
  logic           mem_ready = 1'b0;
  logic           q_full;
  logic [CW-1:0]  q_count;
`ifdef STORE_FLUSH_EN
  logic           flush = 1'b0;
`endif

  always #5 clk = ~clk;

  store_commit_ctrl #(.STORER_NUM(N), .WORD_SIZE(W),
                      .RB_INDEX(R), .QDEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_rb(st_rb), .st_grant(st_grant),
    .commit_valid(commit_valid), .commit_rb(commit_rb),
    .commit_ack(commit_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
`ifdef STORE_FLUSH_EN
    .flush(flush),
`endif
    .q_full(q_full), .q_count(q_count)
  );

  int total = 0;
  int bad = 0;

  bit           rs_v [N];
  logic [W-1:0] rs_a [N];
  logic [W-1:0] rs_d [N];
  logic [R-1:0] rs_r [N];

  // reference model: 0 free, 1 waiting for commit, 2 queued for memory
  int           m_st [D];
  logic [W-1:0] m_a [D];
  logic [W-1:0] m_d [D];
  logic [R-1:0] m_r [D];
  int           m_q [$];
  int           m_rr;
  bit           m_wr;
  logic [W-1:0] m_wa;
  logic [W-1:0] m_wd;
  bit           m_ack;

  typedef struct {
    bit         rst;
    logic [1:0] v;
    bit         cv;
    logic [3:0] crb;
    bit         mr;
    logic [1:0] g;
    bit         ack;
    bit         we;
    logic [31:0] a;
    logic [31:0] d;
    bit         full;
    int         cnt;
  } vec_t;
  vec_t tv [$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rs();
    for (int k = 0; k < N; k++) begin
      st_valid[k]        = rs_v[k];
      st_addr[k*W +: W]  = rs_a[k];
      st_data[k*W +: W]  = rs_d[k];
      st_rb[k*R +: R]    = rs_r[k];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    st_valid = '1;
    commit_valid = 1'b0;
    mem_ready = 1'b0;
`ifdef STORE_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
    chk("rst_grant", st_grant, 0);
    tick();
    chk("rst_ack", commit_ack, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_full", q_full, 0);
    chk("rst_count", q_count, 0);
    reset = 1'b0;
    st_valid = '0;
    for (int k = 0; k < N; k++) rs_v[k] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_st[i] = 0;
    m_q.delete();
    m_rr = 0;
    m_wr = 1'b0;
    m_ack = 1'b0;
  endtask

  function automatic bit rb_used(logic [R-1:0] r);
    for (int i = 0; i < D; i++)
      if (m_st[i] != 0 && m_r[i] == r) return 1'b1;
    for (int k = 0; k < N; k++)
      if (rs_v[k] && rs_r[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_grantee(bit fl);
    int nfree;
    nfree = 0;
    for (int i = 0; i < D; i++) if (m_st[i] == 0) nfree++;
    if (fl || nfree == 0) return -1;
    for (int k = 0; k < N; k++)
      if (rs_v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic model_step(bit cv, logic [R-1:0] crb, bit mr,
                            bit fl, int g);
    int slot;
    int hit;
    slot = -1;
    hit = -1;
    for (int i = 0; i < D; i++) if (slot < 0 && m_st[i] == 0) slot = i;
    for (int i = 0; i < D; i++)
      if (m_st[i] == 1 && m_r[i] == crb) hit = i;
    if (fl)
      for (int i = 0; i < D; i++) if (m_st[i] == 1) m_st[i] = 0;
    if (m_wr) begin
      if (mr) begin
        m_st[m_q[0]] = 0;
        void'(m_q.pop_front());
        m_wr = 1'b0;
      end
    end else if (m_q.size() != 0) begin
      m_wr = 1'b1;
      m_wa = m_a[m_q[0]];
      m_wd = m_d[m_q[0]];
    end
    m_ack = cv && !fl && hit >= 0;
    if (m_ack) begin
      m_st[hit] = 2;
      m_q.push_back(hit);
    end
    if (g >= 0) begin
      m_st[slot] = 1;
      m_a[slot] = rs_a[g];
      m_d[slot] = rs_d[g];
      m_r[slot] = rs_r[g];
      m_rr = (g + 1) % N;
    end
  endtask

  function automatic int model_count();
    int c;
    c = 0;
    for (int i = 0; i < D; i++) if (m_st[i] != 0) c++;
    return c;
  endfunction

  initial begin
    // rst v cv crb mr | g ack we addr data full cnt
    tv.push_back('{1, 2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1});
    tv.push_back('{0, 2'b00, 1, 3, 0, 2'b00, 1, 0, 0, 0, 0, 1});
    tv.push_back('{0, 2'b00, 0, 0, 0, 2'b00, 0, 1, 32'h10, 32'hAA, 0, 1});
    tv.push_back('{0, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 2'b00, 1, 5, 0, 2'b00, 0, 0, 0, 0, 0, 0});
    tv.push_back('{1, 2'b11, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1});
    tv.push_back('{0, 2'b11, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 2});
    tv.push_back('{0, 2'b11, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 3});
    tv.push_back('{0, 2'b11, 0, 0, 0, 2'b10, 0, 0, 0, 0, 1, 4});
    tv.push_back('{0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 4});
    tv.push_back('{0, 2'b11, 1, 5, 0, 2'b00, 0, 0, 0, 0, 1, 4});
    tv.push_back('{1, 2'b01, 1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 1});
    tv.push_back('{0, 2'b00, 1, 3, 0, 2'b00, 1, 0, 0, 0, 0, 1});
    tv.push_back('{0, 2'b00, 0, 0, 0, 2'b00, 0, 1, 32'h10, 32'hAA, 0, 1});
    tv.push_back('{0, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0});

    rs_a[0] = 32'h10; rs_d[0] = 32'hAA; rs_r[0] = 4'd3;
    rs_a[1] = 32'h20; rs_d[1] = 32'hBB; rs_r[1] = 4'd4;
    repeat (2) @(posedge clk);

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      for (int k = 0; k < N; k++) rs_v[k] = tv[i].v[k];
      drive_rs();
      commit_valid = tv[i].cv;
      commit_rb = tv[i].crb;
      mem_ready = tv[i].mr;
      #1;
      chk($sformatf("v%0d_grant", i), st_grant, tv[i].g);
      tick();
      chk($sformatf("v%0d_ack", i), commit_ack, tv[i].ack);
      chk($sformatf("v%0d_we", i), mem_we, tv[i].we);
      chk($sformatf("v%0d_full", i), q_full, tv[i].full);
      chk($sformatf("v%0d_cnt", i), q_count, tv[i].cnt);
      if (tv[i].we) begin
        chk($sformatf("v%0d_addr", i), mem_addr, tv[i].a);
        chk($sformatf("v%0d_data", i), mem_wdata, tv[i].d);
      end
      commit_valid = 1'b0;
      mem_ready = 1'b0;
    end

    // memory back-pressure, ordering and async reset mid-write
    do_reset();
    rs_v[0] = 1; rs_a[0] = 32'h100; rs_d[0] = 32'h222; rs_r[0] = 4'd2;
    drive_rs();
    tick();
    rs_a[0] = 32'h200; rs_d[0] = 32'h777; rs_r[0] = 4'd7;
    drive_rs();
    tick();
    rs_v[0] = 0;
    drive_rs();
    chk("bp_cnt2", q_count, 2);
    commit_valid = 1; commit_rb = 4'd2;
    tick();
    chk("bp_ack2", commit_ack, 1);
    commit_rb = 4'd7;
    tick();
    chk("bp_ack7", commit_ack, 1);
    chk("bp_we_start", mem_we, 1);
    commit_valid = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_we", mem_we, 1);
      chk("bp_hold_addr", mem_addr, 32'h100);
      chk("bp_hold_data", mem_wdata, 32'h222);
    end
    mem_ready = 1;
    tick();
    chk("bp_gap_we", mem_we, 0);
    chk("bp_gap_cnt", q_count, 1);
    mem_ready = 0;
    tick();
    chk("bp_second_we", mem_we, 1);
    chk("bp_second_addr", mem_addr, 32'h200);
    chk("bp_second_data", mem_wdata, 32'h777);
    #2;
    reset = 1'b1;
    #1;
    chk("async_we", mem_we, 0);
    chk("async_cnt", q_count, 0);
    tick();
    reset = 1'b0;

`ifdef STORE_FLUSH_EN
    do_reset();
    rs_v[0] = 1;
    for (int s = 1; s <= 3; s++) begin
      rs_a[0] = 32'h30 + s; rs_d[0] = 32'h40 + s; rs_r[0] = R'(s);
      drive_rs();
      tick();
    end
    rs_v[0] = 0;
    drive_rs();
    commit_valid = 1; commit_rb = 4'd1;
    tick();
    chk("fl_ack", commit_ack, 1);
    commit_valid = 1; commit_rb = 4'd2;
    flush = 1;
    rs_v[0] = 1; rs_r[0] = 4'd9;
    drive_rs();
    #1;
    chk("fl_grant", st_grant, 0);
    tick();
    chk("fl_cnt", q_count, 1);
    chk("fl_noack", commit_ack, 0);
    chk("fl_we", mem_we, 1);
    chk("fl_addr", mem_addr, 32'h31);
    flush = 0; commit_valid = 0;
    rs_v[0] = 0;
    drive_rs();
    mem_ready = 1;
    tick();
    chk("fl_drain", q_count, 0);
    mem_ready = 0;
`endif

    // random traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit           cv;
      bit           mr;
      bit           fl;
      logic [R-1:0] crb;
      logic [R-1:0] nr;
      logic [N-1:0] eg_v;
      int           eg;
      logic [R-1:0] dl [$];
      for (int k = 0; k < N; k++) begin
        if (!rs_v[k] && $urandom_range(0, 2) == 0) begin
          nr = R'($urandom_range(0, 15));
          while (rb_used(nr)) nr = R'($urandom_range(0, 15));
          rs_v[k] = 1'b1;
          rs_a[k] = $urandom;
          rs_d[k] = $urandom;
          rs_r[k] = nr;
        end
      end
      dl.delete();
      for (int i = 0; i < D; i++) if (m_st[i] == 1) dl.push_back(m_r[i]);
      cv = 1'($urandom_range(0, 1));
      if (dl.size() > 0 && $urandom_range(0, 3) != 0)
        crb = dl[$urandom_range(0, dl.size() - 1)];
      else
        crb = R'($urandom_range(0, 15));
      mr = 1'($urandom_range(0, 1));
      fl = 1'b0;
`ifdef STORE_FLUSH_EN
      fl = ($urandom_range(0, 15) == 0);
      flush = fl;
`endif
      drive_rs();
      commit_valid = cv;
      commit_rb = crb;
      mem_ready = mr;
      #1;
      eg = exp_grantee(fl);
      eg_v = '0;
      if (eg >= 0) eg_v[eg] = 1'b1;
      chk("rnd_grant", st_grant, eg_v);
      tick();
      model_step(cv, crb, mr, fl, eg);
      if (eg >= 0) rs_v[eg] = 1'b0;
      chk("rnd_ack", commit_ack, m_ack);
      chk("rnd_we", mem_we, m_wr);
      chk("rnd_cnt", q_count, model_count());
      chk("rnd_full", q_full, model_count() == D);
      if (m_wr) begin
        chk("rnd_addr", mem_addr, m_wa);
        chk("rnd_data", mem_wdata, m_wd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_commit_ctrl.md
Name: store_commit_ctrl

Overview:
- Sits between the store reservation stations and data memory in the Tomasulo core.
- Each cycle, round-robin grants one completed store (address, data, RB index) into a small store queue.
- Holds each entry until the reorder buffer commits that RB index, then writes committed stores to memory in commit order over a ready handshake.
- Stores never reach memory speculatively.

Parameters:
STORER_NUM, 2, number of store reservation stations feeding the block
WORD_SIZE, 32, address/data width
RB_INDEX, 4, reorder-buffer index width
QDEPTH, 4, store queue entries (power of two, >= 2)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
st_valid  in  STORER_NUM  per-RS "store computed" request, held until granted
st_addr  in  STORER_NUM*WORD_SIZE  effective addresses, RS i at slice i
st_data  in  STORER_NUM*WORD_SIZE  store data
st_rb  in  STORER_NUM*RB_INDEX  RB index of each store
st_grant  out  STORER_NUM  one-hot, RS i captured this cycle
commit_valid  in  1  ROB head is a store being committed
commit_rb  in  RB_INDEX  RB index being committed
commit_ack  out  1  commit matched an entry (registered)
mem_we  out  1  memory write request
mem_addr  out  WORD_SIZE  write address
mem_wdata  out  WORD_SIZE  write data
mem_ready  in  1  memory accepts write this cycle
q_full  out  1  no FREE entry
q_count  out  $clog2(QDEPTH)+1  non-FREE entries

Behaviour:
- Reset (async) clears all entries to FREE and the commit-order FIFO to empty, and sets the RR pointer to 0.
- Reset drives st_grant=0, commit_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, q_full=0, q_count=0.
- Reset asserted mid-write drops mem_we immediately; the pending write is lost.
- Entry states: FREE, DONE (captured, awaiting commit), COMMITTED (queued for memory).
- Grant (combinational):
  - When any st_valid and a FREE entry exists, st_grant selects the first requester at or after the RR pointer.
  - At posedge the lowest-numbered FREE entry captures {addr, data, rb} and becomes DONE; the RR pointer moves to grantee+1 mod STORER_NUM.
  - When q_full, st_grant=0.
  - An entry freed by a memory write this cycle is usable next cycle, not this cycle.
- Commit:
  - At posedge with commit_valid, CAM-match commit_rb against DONE entries only.
  - On a hit: entry becomes COMMITTED, its slot index is pushed to the commit FIFO, and commit_ack=1 for exactly one cycle following.
  - On a miss: commit_ack=0 next cycle; the ROB retries.
  - A store granted in the same cycle as its commit does not match; the commit misses.
  - Multiple DONE entries with equal rb are illegal.
- Memory FSM:
  - IDLE -> WRITE when the commit FIFO is non-empty. Head slot drives mem_addr/mem_wdata; mem_we=1.
  - In WRITE, mem_we stays high and addr/data stay stable until mem_ready=1 at posedge. Then the entry goes FREE, the FIFO pops, and the FSM returns to IDLE.
  - Minimum one IDLE cycle between writes; one write per two cycles peak.
- q_count/q_full are registered from post-update state. Grant, commit and memory pop may all occur in one cycle.

Optional Feature:
STORE_FLUSH_EN
- With it: adds input flush (1). At posedge with flush=1, all DONE entries become FREE.
- COMMITTED entries and an in-progress write are unaffected.
- Flush has priority over a same-cycle commit: commit_ack=0 next cycle.
- Flush overrides a same-cycle grant: st_grant is forced 0.
- Without it: no flush port; entries leave only via commit and memory write.

Decomposition:
- parameters.v (shared): WORD_SIZE, RB_INDEX, STORER_NUM, and entry-state encodings ST_FREE/ST_DONE/ST_COMMITTED.
- One sub-module, rr_arbiter: parameterised N-way round-robin with request, pointer and one-hot grant. Reusable for the CDB arbiter.

Test Plan:
- Reset, then RS0 st_valid, addr 0x10, data 0xAA, rb 3 -> st_grant=01; q_count=1 next cycle; commit rb 3 -> commit_ack=1; mem_we=1, addr 0x10, data 0xAA; mem_ready -> q_count=0.
- RS0 and RS1 requesting continuously -> grants alternate 01,10,01,10 until q_full=1 after 4; then st_grant=00.
- Commit rb 5 with no matching entry -> commit_ack=0, q_count unchanged, mem_we=0.
- Commit rb 2 then rb 7 while mem_ready=0 for 5 cycles -> mem_we held with rb2's addr/data stable; rb7's write follows after an IDLE cycle.
- Async reset pulse while mem_we=1 -> mem_we=0 within the same cycle, q_count=0.
- (STORE_FLUSH_EN) 2 DONE + 1 COMMITTED, flush=1 -> q_count=1; committed store still written.
